// File: rtl/uart_tx_arbiter_pkg.sv
// ============================================================================
// uart_pkg : shared types and constants for the UART transmit arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int c_DATA_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    // Round-robin successor of a granted index
    function automatic int rr_next(input int g, input int n);
        return (g == n - 1) ? 0 : g + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
// ============================================================================
// uart_tx_arbiter_if : requester handshake and transmitter-side signal bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface uart_tx_arbiter_if import uart_pkg::*; #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = c_DATA_WIDTH_DEFAULT
);
    localparam int GW = $clog2(N_REQ);

    logic                        en;
    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ*DATA_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]            req_ready;
    logic [DATA_WIDTH-1:0]       tx_din;
    logic                        tx_req;
    logic                        tx_busy;
    logic [GW-1:0]               grant_id;
    logic                        active;
    logic                        timeout_err;

    modport master (
        input  en, req_valid, req_data, tx_busy,
        output req_ready, tx_din, tx_req, grant_id, active, timeout_err
    );

    modport slave (
        output en, req_valid, req_data, tx_busy,
        input  req_ready, tx_din, tx_req, grant_id, active, timeout_err
    );

endinterface

`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
// ============================================================================
// uart_rr_pick : combinational round-robin winner search starting at ptr
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_rr_pick import uart_pkg::*; #(
    parameter int N_REQ = 4
) (
    input  wire logic [N_REQ-1:0]         req,
    input  wire logic [$clog2(N_REQ)-1:0] ptr,
    output logic      [$clog2(N_REQ)-1:0] gnt_idx,
    output logic                          any
);
    localparam int GW = $clog2(N_REQ);

    logic [N_REQ-1:0]   w_mask;
    logic [2*N_REQ-1:0] w_dbl;
    logic               w_found;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_mask[i] = (i >= int'(ptr));
        end
    end

    // Lower half holds requests at or above ptr, upper half the wrapped copy
    assign w_dbl = {req, req & w_mask};

    always_comb begin
        gnt_idx = '0;
        w_found = 1'b0;
        for (int i = 0; i < 2*N_REQ; i++) begin
            if (!w_found && w_dbl[i]) begin
                w_found = 1'b1;
                gnt_idx = (i >= N_REQ) ? GW'(i - N_REQ) : GW'(i);
            end
        end
    end

    assign any = |req;

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// uart_tx_arbiter : round-robin sharing of one UART transmitter among N_REQ
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_tx_arbiter import uart_pkg::*; #(
    parameter int N_REQ       = 4,
    parameter int DATA_WIDTH  = c_DATA_WIDTH_DEFAULT,
    parameter int ACK_TIMEOUT = 8
) (
    input  wire logic          CLK,
    input  wire logic          rst_n,
    uart_tx_arbiter_if.master  bus
);
    localparam int GW = $clog2(N_REQ);
    localparam int CW = $clog2(ACK_TIMEOUT);

    state_t                r_state;
    state_t                w_state_nxt;

    logic [GW-1:0]         r_rr_ptr;
    logic [GW-1:0]         w_pick_idx;
    logic                  w_pick_any;
    logic [DATA_WIDTH-1:0] w_pick_data;
    logic [N_REQ-1:0]      w_pick_onehot;

    logic [CW-1:0]         r_ack_cnt;

    logic                  w_grant;
    logic                  w_ack_clr;
    logic                  w_ack_inc;
    logic                  w_timeout;
    logic                  w_done;

    logic                  r_tx_req;
    logic [DATA_WIDTH-1:0] r_tx_din;
    logic [N_REQ-1:0]      r_req_ready;
    logic [GW-1:0]         r_grant_id;
    logic                  r_active;
    logic                  r_timeout_err;

    uart_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req     (bus.req_valid),
        .ptr     (r_rr_ptr),
        .gnt_idx (w_pick_idx),
        .any     (w_pick_any)
    );

    assign w_pick_data   = bus.req_data[int'(w_pick_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign w_pick_onehot = N_REQ'(1) << w_pick_idx;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_ack_clr   = 1'b0;
        w_ack_inc   = 1'b0;
        w_timeout   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                // A busy line here belongs to someone else; hold off
                if (bus.en && w_pick_any && !bus.tx_busy) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                w_ack_clr   = 1'b1;
                w_state_nxt = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (bus.tx_busy) begin
                    w_state_nxt = WAIT_DONE;
                end else if (r_ack_cnt == CW'(ACK_TIMEOUT - 1)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_ack_inc   = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_req      <= 1'b0;
            r_tx_din      <= '0;
            r_req_ready   <= '0;
            r_grant_id    <= '0;
            r_active      <= 1'b0;
            r_timeout_err <= 1'b0;
            r_rr_ptr      <= '0;
            r_ack_cnt     <= '0;
        end else begin
            r_tx_req      <= w_grant;
            r_req_ready   <= w_grant ? w_pick_onehot : '0;
            r_timeout_err <= w_timeout;

            if (w_grant) begin
                r_tx_din   <= w_pick_data;
                r_grant_id <= w_pick_idx;
                r_rr_ptr   <= GW'(rr_next(int'(w_pick_idx), N_REQ));
                r_active   <= 1'b1;
            end else if (w_timeout || w_done) begin
                r_active   <= 1'b0;
            end

            if (w_ack_clr) begin
                r_ack_cnt <= '0;
            end else if (w_ack_inc) begin
                r_ack_cnt <= r_ack_cnt + 1'b1;
            end
        end
    end

    assign bus.tx_req      = r_tx_req;
    assign bus.tx_din      = r_tx_din;
    assign bus.req_ready   = r_req_ready;
    assign bus.grant_id    = r_grant_id;
    assign bus.active      = r_active;
    assign bus.timeout_err = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// tb_uart_tx_arbiter : scoreboard bench for uart_tx_arbiter with a UART TX model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx_arbiter;

    localparam int N            = 4;
    localparam int DW           = 8;
    localparam int CLKS_PER_BIT = 10;
    localparam int FRAME_BITS   = 11;

    logic CLK   = 1'b0;
    logic rst_n = 1'b1;

    always #50 CLK = ~CLK;  // 10 MHz

    uart_tx_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW)) bus();

    uart_tx_arbiter #(
        .N_REQ       (N),
        .DATA_WIDTH  (DW),
        .ACK_TIMEOUT (8)
    ) dut (
        .CLK   (CLK),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- transmitter model: start, 8 data LSB first, odd parity, stop
    logic        m_busy;
    logic [10:0] m_frame;
    int          m_bit;
    int          m_clk;
    logic        m_line;
    logic        tie_low = 1'b0;

    always @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_frame <= '1;
            m_bit   <= 0;
            m_clk   <= 0;
        end else if (!m_busy) begin
            if (bus.tx_req && !tie_low) begin
                m_busy  <= 1'b1;
                m_frame <= {1'b1, ~^bus.tx_din, bus.tx_din, 1'b0};
                m_bit   <= 0;
                m_clk   <= 0;
            end
        end else if (m_clk == CLKS_PER_BIT - 1) begin
            m_clk <= 0;
            if (m_bit == FRAME_BITS - 1) m_busy <= 1'b0;
            else                         m_bit  <= m_bit + 1;
        end else begin
            m_clk <= m_clk + 1;
        end
    end

    assign m_line      = m_busy ? m_frame[m_bit] : 1'b1;
    assign bus.tx_busy = tie_low ? 1'b0 : m_busy;

    // ---------------- checking
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // ---------------- requesters: per-source byte FIFOs
    logic [7:0] rbuf [N][16];
    int         rhead [N];
    int         rtail [N];

    initial begin
        for (int i = 0; i < N; i++) begin
            rhead[i] = 0;
            rtail[i] = 0;
        end
        bus.req_valid = '0;
        bus.req_data  = '0;
        forever begin
            @(negedge CLK);
            for (int i = 0; i < N; i++) begin
                if (bus.req_ready[i] && rhead[i] < rtail[i]) rhead[i]++;
                bus.req_valid[i]        = (rhead[i] < rtail[i]);
                bus.req_data[i*DW +: DW] = rbuf[i][rhead[i] % 16];
            end
        end
    end

    // ---------------- scoreboard and monitor
    int         exp_id  [$];
    logic [7:0] exp_dat [$];
    int         exp_ptr     = 0;
    int         grants      = 0;
    int         cyc         = 0;
    int         fall_cyc    = 0;
    logic       prev_req    = 1'b0;
    logic       prev_busy   = 1'b0;
    logic       gap_chk     = 1'b0;
    logic       gap_armed   = 1'b0;
    logic       to_expected = 1'b0;

    initial begin
        int         id;
        logic [7:0] d;
        forever begin
            @(negedge CLK);
            cyc++;
            if (prev_busy && !bus.tx_busy) fall_cyc = cyc;
            if (bus.tx_req) begin
                grants++;
                chk("tx_req_single_cycle", 32'(prev_req), 0);
                if (exp_id.size() == 0) begin
                    chk("unexpected_grant", 1, 0);
                end else begin
                    id = exp_id.pop_front();
                    d  = exp_dat.pop_front();
                    chk("grant_id", 32'(bus.grant_id), id);
                    chk("tx_din", 32'(bus.tx_din), 32'(d));
                    chk("req_ready", 32'(bus.req_ready), 32'(1) << id);
                end
                if (gap_chk) begin
                    if (gap_armed) chk("b2b_gap", cyc - fall_cyc, 2);
                    gap_armed = 1'b1;
                end
            end else if (bus.req_ready != '0) begin
                chk("stray_ready", 32'(bus.req_ready), 0);
            end
            if (bus.timeout_err && !to_expected) chk("spurious_timeout", 1, 0);
            if (!gap_chk) gap_armed = 1'b0;
            prev_req  = bus.tx_req;
            prev_busy = bus.tx_busy;
        end
    end

    // ---------------- helpers
    function automatic int rr_model(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++) begin
            if (m[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Load bytes into the requesters and push the predicted grant sequence
    task automatic run_batch(input int c0, input int c1, input int c2, input int c3,
                             input logic [7:0] base);
        int         c [N];
        int         k [N];
        logic [7:0] b [N][8];
        logic [N-1:0] m;
        int         g;
        c = '{c0, c1, c2, c3};
        for (int i = 0; i < N; i++) begin
            k[i] = 0;
            for (int j = 0; j < c[i]; j++) begin
                b[i][j] = base + 8'(16*i + j);
                rbuf[i][rtail[i] % 16] = b[i][j];
                rtail[i]++;
            end
        end
        forever begin
            for (int i = 0; i < N; i++) m[i] = (c[i] > 0);
            if (m == '0) break;
            g = rr_model(m, exp_ptr);
            exp_id.push_back(g);
            exp_dat.push_back(b[g][k[g]]);
            k[g]++;
            c[g]--;
            exp_ptr = (g + 1) % N;
        end
    endtask

    task automatic wait_txreq(input int budget, output int n);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!bus.tx_req && n < budget);
        if (!bus.tx_req) chk("tx_req_wait_expired", 0, 1);
    endtask

    task automatic wait_idle(input int budget);
        int  n;
        logic pend;
        n = 0;
        forever begin
            @(negedge CLK);
            n++;
            pend = 1'b0;
            for (int i = 0; i < N; i++) if (rhead[i] != rtail[i]) pend = 1'b1;
            if (exp_id.size() == 0 && !pend && !bus.active && !bus.tx_busy) break;
            if (n >= budget) begin
                chk("idle_wait_expired", 0, 1);
                break;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tx_req"},      32'(bus.tx_req), 0);
        chk({tag, "_tx_din"},      32'(bus.tx_din), 0);
        chk({tag, "_req_ready"},   32'(bus.req_ready), 0);
        chk({tag, "_grant_id"},    32'(bus.grant_id), 0);
        chk({tag, "_active"},      32'(bus.active), 0);
        chk({tag, "_timeout_err"}, 32'(bus.timeout_err), 0);
    endtask

    // ---------------- main sequence
    initial begin
        int          n;
        int          g0;
        int          p0;
        logic [10:0] frame;

        bus.en = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge CLK);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge CLK);

        // Single request from source 2 carrying A5
        rbuf[2][rtail[2] % 16] = 8'hA5;
        rtail[2]++;
        exp_id.push_back(2);
        exp_dat.push_back(8'hA5);
        exp_ptr = 3;
        repeat (3) @(negedge CLK);
        bus.en = 1'b1;
        wait_txreq(10, n);
        chk("grant_latency", n, 1);
        chk("single_active", 32'(bus.active), 1);
        // Bit b is driven for cycles 1+10b..10+10b after the tx_req cycle
        repeat (6) @(negedge CLK);
        for (int b = 0; b < FRAME_BITS; b++) begin
            frame[b] = m_line;
            if (b < FRAME_BITS - 1) repeat (CLKS_PER_BIT) @(negedge CLK);
        end
        chk("line_frame_a5", 32'(frame), 32'({1'b1, 1'b1, 8'hA5, 1'b0}));
        wait_idle(300);
        chk("tx_din_hold", 32'(bus.tx_din), 32'h0A5);
        chk("active_after_frame", 32'(bus.active), 0);
        bus.en = 1'b0;

        // Pointer wrap: ptr 3, requests 1001
        run_batch(1, 0, 0, 1, 8'h40);
        repeat (3) @(negedge CLK);
        bus.en = 1'b1;
        wait_idle(600);
        bus.en = 1'b0;

        // Ack timeout with the busy flag held low
        tie_low     = 1'b1;
        to_expected = 1'b1;
        run_batch(0, 1, 0, 0, 8'h60);
        repeat (3) @(negedge CLK);
        bus.en = 1'b1;
        wait_txreq(10, n);
        chk("timeout_active_at_issue", 32'(bus.active), 1);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!bus.timeout_err && n < 30);
        // Eight WAIT_ACK cycles (count 0..7), then the registered pulse
        chk("timeout_latency", n, 9);
        chk("timeout_active_low", 32'(bus.active), 0);
        @(negedge CLK);
        chk("timeout_pulse_width", 32'(bus.timeout_err), 0);
        bus.en      = 1'b0;
        to_expected = 1'b0;
        tie_low     = 1'b0;
        repeat (2) @(negedge CLK);

        // en held low with all four pending, then released
        g0 = grants;
        p0 = exp_ptr;
        run_batch(2, 2, 2, 2, 8'h80);
        repeat (20) @(negedge CLK);
        chk("en_low_no_grant", grants - g0, 0);
        chk("en_low_tx_req", 32'(bus.tx_req), 0);
        bus.en  = 1'b1;
        gap_chk = 1'b1;
        wait_txreq(5, n);
        chk("en_rise_latency", n, 1);
        chk("en_rise_grant", 32'(bus.grant_id), p0);
        wait_idle(2000);
        gap_chk = 1'b0;
        bus.en  = 1'b0;

        // Reset pulse during WAIT_DONE
        run_batch(0, 0, 1, 0, 8'hC0);
        repeat (3) @(negedge CLK);
        bus.en = 1'b1;
        wait_txreq(10, n);
        repeat (20) @(negedge CLK);
        chk("pre_reset_busy", 32'(bus.tx_busy), 1);
        chk("pre_reset_active", 32'(bus.active), 1);
        bus.en = 1'b0;
        #10 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        exp_ptr = 0;
        @(negedge CLK);
        rst_n = 1'b1;
        repeat (2) @(negedge CLK);

        // All four continuously valid from pointer 0: 0,1,2,3,0
        run_batch(2, 1, 1, 1, 8'hD0);
        repeat (3) @(negedge CLK);
        bus.en  = 1'b1;
        gap_chk = 1'b1;
        wait_idle(2000);
        gap_chk = 1'b0;
        bus.en  = 1'b0;
        chk("scoreboard_drained", exp_id.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
